// File: rtl/cpu_pkg.sv
// Shared types and constants for the 32-bit RISC core pipeline.
// Holds the IF/ID register layout, the canonical NOP and the fetch state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } ifid_t;

  // A bubble carries no instruction, so its PC fields are zeroed as well.
  localparam ifid_t IFID_BUBBLE = '{
    instr:   NOP,
    pc:      '0,
    pcplus4: '0,
    valid:   1'b0
  };

endpackage

// File: rtl/ifetch_stage_ifid_reg.sv
// IF/ID pipeline register: synchronous reset, flush to a bubble, or hold on stall.
// Flush outranks hold, so a redirect during a stall still kills the wrong-path slot.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= IFID_BUBBLE;
    end else if (flush) begin
      q <= IFID_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational imem and fills IF/ID.
// A misaligned or out-of-range PC parks the stage in FAULT until reset.
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter int          n        = XLEN,
  parameter int          r        = 7,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic [r-1:0] imem_addr,
  input  logic [n-1:0] imem_data,
  output logic [n-1:0] pc,
  output logic [n-1:0] id_instr,
  output logic [n-1:0] id_pc,
  output logic [n-1:0] id_pcplus4,
  output logic         id_valid,
  output logic         fault
);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [n-1:0] pc_q;
  logic [n-1:0] pc_next;
  logic [n-1:0] pc_plus4;

  logic misaligned;
  logic out_of_range;
  logic bad_pc;

  logic  ifid_hold;
  logic  ifid_flush;
  ifid_t ifid_d;
  ifid_t ifid_q;

  assign pc_plus4  = pc_q + n'(4);
  assign imem_addr = pc_q[r+1:2];

  // Any set bit above the word index means the PC lies beyond imem; no aliasing wrap.
  assign misaligned   = |pc_q[1:0];
  assign out_of_range = |pc_q[n-1:r+2];
  assign bad_pc       = misaligned | out_of_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

  // Priority within RUN: fault detect, then redirect, then stall, then advance.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    case (state)
      RUN: begin
        if (bad_pc) begin
          state_next = FAULT;
          ifid_flush = 1'b1;
        end else if (redirect) begin
          pc_next    = redirect_pc;
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold  = 1'b1;
        end else begin
          pc_next    = pc_plus4;
        end
      end
      FAULT: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_next = FAULT;
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_comb begin
    ifid_d         = IFID_BUBBLE;
    ifid_d.instr   = imem_data;
    ifid_d.pc      = pc_q;
    ifid_d.pcplus4 = pc_plus4;
    ifid_d.valid   = 1'b1;
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .hold  (ifid_hold),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign pc         = pc_q;
  assign id_instr   = ifid_q.instr;
  assign id_pc      = ifid_q.pc;
  assign id_pcplus4 = ifid_q.pcplus4;
  assign id_valid   = ifid_q.valid;
  assign fault      = (state == FAULT);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage; imem model returns 32'hA000_0000 | word_index.
module tb_ifetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;
  logic        id_valid;
  logic        fault;

  int total = 0;
  int bad   = 0;

  ifetch_stage #(.n(32), .r(7), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc          (pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pcplus4  (id_pcplus4),
    .id_valid    (id_valid),
    .fault       (fault)
  );

  assign imem_data = 32'hA000_0000 | {25'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=0", id_instr); end
    total++; if (id_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_id_pc got=%h exp=0", id_pc); end
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault got=%b exp=0", fault); end
    total++; if (imem_addr !== 7'h0) begin bad++; $display("[TB] FAIL reset_imem_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (pc !== 32'(4*i)) begin bad++; $display("[TB] FAIL run_pc[%0d] got=%h exp=%h", i, pc, 32'(4*i)); end
      total++; if (id_instr !== (32'hA000_0000 | 32'(i-1))) begin bad++; $display("[TB] FAIL run_instr[%0d] got=%h exp=%h", i, id_instr, 32'hA000_0000 | 32'(i-1)); end
      total++; if (id_pc !== 32'(4*(i-1))) begin bad++; $display("[TB] FAIL run_id_pc[%0d] got=%h exp=%h", i, id_pc, 32'(4*(i-1))); end
      total++; if (id_pcplus4 !== 32'(4*i)) begin bad++; $display("[TB] FAIL run_pcplus4[%0d] got=%h exp=%h", i, id_pcplus4, 32'(4*i)); end
      total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL run_valid[%0d] got=%b exp=1", i, id_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pc !== 32'h8) begin bad++; $display("[TB] FAIL stall_pc[%0d] got=%h exp=8", i, pc); end
      total++; if (id_pc !== 32'h4) begin bad++; $display("[TB] FAIL stall_id_pc[%0d] got=%h exp=4", i, id_pc); end
      total++; if (id_instr !== 32'hA000_0001) begin bad++; $display("[TB] FAIL stall_instr[%0d] got=%h exp=A0000001", i, id_instr); end
      total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", i, id_valid); end
    end
    stall = 1'b0;
    tick();
    total++; if (pc !== 32'hC) begin bad++; $display("[TB] FAIL unstall_pc got=%h exp=C", pc); end
    total++; if (id_pc !== 32'h8) begin bad++; $display("[TB] FAIL unstall_id_pc got=%h exp=8", id_pc); end
    total++; if (id_instr !== 32'hA000_0002) begin bad++; $display("[TB] FAIL unstall_instr got=%h exp=A0000002", id_instr); end
  endtask

  task automatic test_redirect();
    tick();
    total++; if (pc !== 32'h10) begin bad++; $display("[TB] FAIL pre_redir_pc got=%h exp=10", pc); end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    total++; if (pc !== 32'h40) begin bad++; $display("[TB] FAIL redir_pc got=%h exp=40", pc); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_valid got=%b exp=0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("[TB] FAIL redir_instr got=%h exp=0", id_instr); end
    tick();
    total++; if (id_pc !== 32'h40) begin bad++; $display("[TB] FAIL redir_id_pc got=%h exp=40", id_pc); end
    total++; if (id_instr !== 32'hA000_0010) begin bad++; $display("[TB] FAIL redir_fetch got=%h exp=A0000010", id_instr); end
    total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL redir_fetch_valid got=%b exp=1", id_valid); end
    total++; if (pc !== 32'h44) begin bad++; $display("[TB] FAIL redir_next_pc got=%h exp=44", pc); end
  endtask

  task automatic test_redirect_stall();
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0; stall = 1'b0;
    total++; if (pc !== 32'h20) begin bad++; $display("[TB] FAIL rs_pc got=%h exp=20", pc); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL rs_valid got=%b exp=0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("[TB] FAIL rs_instr got=%h exp=0", id_instr); end
    tick();
    total++; if (id_instr !== 32'hA000_0008) begin bad++; $display("[TB] FAIL rs_fetch got=%h exp=A0000008", id_instr); end
    total++; if (id_pc !== 32'h20) begin bad++; $display("[TB] FAIL rs_id_pc got=%h exp=20", id_pc); end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    total++; if (pc !== 32'h42) begin bad++; $display("[TB] FAIL mis_pc got=%h exp=42", pc); end
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL mis_early_fault got=%b exp=0", fault); end
    tick();
    total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL mis_fault got=%b exp=1", fault); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_valid got=%b exp=0", id_valid); end
    for (int i = 0; i < 10; i++) begin
      redirect = (i % 3 == 0); stall = (i % 2 == 0); redirect_pc = 32'h0;
      tick();
      total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL sticky_fault[%0d] got=%b exp=1", i, fault); end
      total++; if (pc !== 32'h42) begin bad++; $display("[TB] FAIL frozen_pc[%0d] got=%h exp=42", i, pc); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL fault_valid[%0d] got=%b exp=0", i, id_valid); end
    end
    redirect = 1'b0; stall = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL mis_reset_fault got=%b exp=0", fault); end
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL mis_reset_pc got=%h exp=0", pc); end
  endtask

  task automatic test_last_word();
    redirect = 1'b1; redirect_pc = 32'h1F8;
    tick();
    redirect = 1'b0;
    tick();
    total++; if (pc !== 32'h1FC) begin bad++; $display("[TB] FAIL last_pc got=%h exp=1FC", pc); end
    total++; if (imem_addr !== 7'h7F) begin bad++; $display("[TB] FAIL last_addr got=%h exp=7F", imem_addr); end
    tick();
    total++; if (pc !== 32'h200) begin bad++; $display("[TB] FAIL over_pc got=%h exp=200", pc); end
    total++; if (id_instr !== 32'hA000_007F) begin bad++; $display("[TB] FAIL last_instr got=%h exp=A000007F", id_instr); end
    total++; if (id_pcplus4 !== 32'h200) begin bad++; $display("[TB] FAIL last_pcplus4 got=%h exp=200", id_pcplus4); end
    total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL last_valid got=%b exp=1", id_valid); end
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL last_fault got=%b exp=0", fault); end
    total++; if (imem_addr !== 7'h00) begin bad++; $display("[TB] FAIL wrap_addr got=%h exp=00", imem_addr); end
    tick();
    total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL range_fault got=%b exp=1", fault); end
    total++; if (pc !== 32'h200) begin bad++; $display("[TB] FAIL range_pc got=%h exp=200", pc); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL range_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_alias();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0804;
    tick();
    redirect = 1'b0;
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL alias_early got=%b exp=0", fault); end
    tick();
    total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL alias_fault got=%b exp=1", fault); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL alias_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    tick();
    total++; if (id_valid !== 1'b1) begin bad++; $display("[TB] FAIL pre_rst_valid got=%b exp=1", id_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    total++; if (id_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_valid got=%b exp=0", id_valid); end
    total++; if (id_instr !== 32'h0) begin bad++; $display("[TB] FAIL rst_stall_instr got=%h exp=0", id_instr); end
    total++; if (id_pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_stall_id_pc got=%h exp=0", id_pc); end
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_stall_pc got=%h exp=0", pc); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misaligned();
    test_last_word();
    test_alias();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
